// File: rtl/pueo_trig_pkg.sv
// -----------------------------------------------------------------------------
// pueo_trig_pkg
// Shared definitions for the TURF trigger path: source indices, the
// per-source request record, and a small bit-count helper.
// -----------------------------------------------------------------------------
package pueo_trig_pkg;

    localparam int NTURF_SRC = 4;
    localparam int SRC_SOFT  = 0;
    localparam int SRC_PPS   = 1;
    localparam int SRC_EXT   = 2;
    localparam int SRC_RSV   = 3;

    typedef struct packed {
        logic [11:0] trig;
        logic [7:0]  metadata;
    } turf_trig_req_t;

    // Number of set bits in a 4-bit vector (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + {2'b00, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/pueo_turf_trig_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker over four request bits. The search
// starts at ptr and walks upward modulo 4; the first set bit wins.
// Ports:
//   pend [3:0]  request bits
//   ptr  [1:0]  highest-priority index for this pick
//   any         at least one request bit is set
//   idx  [1:0]  winning index (equals ptr when any is low)
// -----------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] pend,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [7:0] dbl_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {pend, pend} >> ptr;
        rot_s = dbl_s[3:0];
        any   = 1'b1;
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s = 2'd0;
                any   = 1'b0;
            end
        endcase
        idx = ptr + off_s;
    end

endmodule

// File: rtl/pueo_turf_trig_arbiter.sv
// -----------------------------------------------------------------------------
// pueo_turf_trig_arbiter
// Shares the single TURF trigger slot between four sources (soft, pps, ext,
// rsv). Each source has a one-deep holding register; on every trigger slot
// at most one pending source is granted round-robin, followed by a
// programmable number of blocked slots. Requests arriving on an occupied
// holding register are dropped and reported.
// Ports:
//   sysclk_i, sysclk_rst_i        clock, synchronous active-high reset
//   slot_ce_i                     trigger-slot strobe
//   running_i                     run active; low blocks acceptance and grants
//   src_enable_i[3:0]             per-source enable
//   holdoff_i                     slots blocked after each grant
//   clear_i                       clears drop flags and drop counter
//   req_trig_i/req_metadata_i     per-source request data
//   req_valid_i[3:0]              per-source single-cycle request
//   trig_o/metadata_o/src_o       granted request (held until next grant)
//   valid_o                       one-cycle grant strobe
//   drop_o[3:0], drop_cnt_o       sticky drop flags, saturating drop count
//   busy_o                        holdoff counter nonzero
// -----------------------------------------------------------------------------
module pueo_turf_trig_arbiter
    import pueo_trig_pkg::*;
#(
    parameter int HOLDOFF_WIDTH  = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      sysclk_i,
    input  logic                      sysclk_rst_i,
    input  logic                      slot_ce_i,
    input  logic                      running_i,
    input  logic [3:0]                src_enable_i,
    input  logic [HOLDOFF_WIDTH-1:0]  holdoff_i,
    input  logic                      clear_i,
    input  logic [3:0][11:0]          req_trig_i,
    input  logic [3:0][7:0]           req_metadata_i,
    input  logic [3:0]                req_valid_i,
    output logic [11:0]               trig_o,
    output logic [7:0]                metadata_o,
    output logic [1:0]                src_o,
    output logic                      valid_o,
    output logic [3:0]                drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                      busy_o
);

    turf_trig_req_t             pending_r [NTURF_SRC];
    logic [3:0]                 pend_r;
    logic [3:0]                 pend_next_s;
    logic [1:0]                 rr_ptr_r;
    logic [HOLDOFF_WIDTH-1:0]   hold_cnt_r;
    logic [HOLDOFF_WIDTH-1:0]   hold_next_s;

    logic [3:0]                 accept_s;
    logic [3:0]                 load_s;
    logic [3:0]                 grant_vec_s;
    logic [3:0]                 drop_s;
    logic [3:0]                 drop_next_s;
    logic                       win_any_s;
    logic [1:0]                 win_idx_s;
    logic                       grant_s;
    logic [2:0]                 drop_num_s;
    logic [DROP_CNT_WIDTH:0]    drop_sum_s;
    logic [DROP_CNT_WIDTH-1:0]  drop_cnt_next_s;

    rr_pick4 u_pick (
        .pend (pend_r),
        .ptr  (rr_ptr_r),
        .any  (win_any_s),
        .idx  (win_idx_s)
    );

    // Acceptance, grant decision, drop detection and holding-register next state.
    always_comb begin
        accept_s    = req_valid_i & src_enable_i & {4{running_i}};
        grant_s     = slot_ce_i & running_i & win_any_s &
                      (hold_cnt_r == {HOLDOFF_WIDTH{1'b0}});
        if (grant_s) begin
            grant_vec_s = 4'b0001 << win_idx_s;
        end else begin
            grant_vec_s = 4'b0000;
        end
        // A held request being granted on this edge frees the slot, so a new
        // request for the same source reloads instead of dropping.
        drop_s      = accept_s & pend_r & ~grant_vec_s;
        load_s      = accept_s & (~pend_r | grant_vec_s);
        if (!running_i) begin
            pend_next_s = 4'b0000;
        end else begin
            pend_next_s = src_enable_i & (load_s | (pend_r & ~grant_vec_s));
        end
    end

    // Slot holdoff counter: reload on grant, count down on idle slots.
    always_comb begin
        hold_next_s = hold_cnt_r;
        if (grant_s) begin
            hold_next_s = holdoff_i;
        end else if (slot_ce_i && (hold_cnt_r != {HOLDOFF_WIDTH{1'b0}})) begin
            hold_next_s = hold_cnt_r - {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            hold_next_s = hold_cnt_r;
        end
    end

    // Drop flags and saturating drop count; drops on a clear edge still register.
    always_comb begin
        drop_num_s = popcount4(drop_s);
        drop_sum_s = {1'b0, drop_cnt_o} + {{(DROP_CNT_WIDTH-2){1'b0}}, drop_num_s};
        if (clear_i) begin
            drop_next_s     = drop_s;
            drop_cnt_next_s = {{(DROP_CNT_WIDTH-3){1'b0}}, drop_num_s};
        end else if (drop_sum_s[DROP_CNT_WIDTH]) begin
            drop_next_s     = drop_o | drop_s;
            drop_cnt_next_s = {DROP_CNT_WIDTH{1'b1}};
        end else begin
            drop_next_s     = drop_o | drop_s;
            drop_cnt_next_s = drop_sum_s[DROP_CNT_WIDTH-1:0];
        end
    end

    // Holding registers, arbitration state and output registers.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            for (int s = 0; s < NTURF_SRC; s++) begin
                pending_r[s].trig     <= 12'h000;
                pending_r[s].metadata <= 8'h00;
            end
            pend_r     <= 4'b0000;
            rr_ptr_r   <= 2'd0;
            hold_cnt_r <= {HOLDOFF_WIDTH{1'b0}};
            valid_o    <= 1'b0;
            trig_o     <= 12'h000;
            metadata_o <= 8'h00;
            src_o      <= 2'd0;
            drop_o     <= 4'b0000;
            drop_cnt_o <= {DROP_CNT_WIDTH{1'b0}};
            busy_o     <= 1'b0;
        end else begin
            for (int s = 0; s < NTURF_SRC; s++) begin
                if (load_s[s]) begin
                    pending_r[s].trig     <= req_trig_i[s];
                    pending_r[s].metadata <= req_metadata_i[s];
                end
            end
            pend_r     <= pend_next_s;
            hold_cnt_r <= hold_next_s;
            busy_o     <= (hold_next_s != {HOLDOFF_WIDTH{1'b0}});
            valid_o    <= grant_s;
            drop_o     <= drop_next_s;
            drop_cnt_o <= drop_cnt_next_s;
            if (grant_s) begin
                trig_o     <= pending_r[win_idx_s].trig;
                metadata_o <= pending_r[win_idx_s].metadata;
                src_o      <= win_idx_s;
                rr_ptr_r   <= win_idx_s + 2'd1;
            end
        end
    end

endmodule

// File: doc/pueo_turf_trig_arbiter.md
# pueo_turf_trig_arbiter

Shares the single TURF-originated trigger slot of the master trigger processor between the four TURF trigger sources (software, PPS, external, reserved). Each source posts single-cycle requests into a one-deep holding register; on each trigger slot (the two qualified cycles per 8-clock command cycle) the block grants at most one pending source round-robin, subject to a programmable slot holdoff. It sits in the sysclk domain between the trigger-control register block and the master trigger process. It also reports dropped requests back to trigger control.

## Interface
Parameters:
- HOLDOFF_WIDTH, 8: width of the slot-holdoff count.
- DROP_CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- sysclk_i  in  1  system clock; the only clock.
- sysclk_rst_i  in  1  synchronous, active-high reset.
- slot_ce_i  in  1  trigger-slot strobe; high two cycles per 8-clock cycle.
- running_i  in  1  run active; low disables all acceptance and grants.
- src_enable_i  in  4  per-source enable; bit 0 soft, 1 pps, 2 ext, 3 rsv.
- holdoff_i  in  HOLDOFF_WIDTH  slots to block after each grant.
- clear_i  in  1  clears drop flags and drop counter.
- req_trig_i  in  4x12  per-source trigger field.
- req_metadata_i  in  4x8  per-source metadata.
- req_valid_i  in  4  per-source single-cycle request.
- trig_o  out  12  granted trigger field.
- metadata_o  out  8  granted metadata.
- src_o  out  2  granted source index.
- valid_o  out  1  one-cycle grant strobe.
- drop_o  out  4  sticky per-source drop flags.
- drop_cnt_o  out  DROP_CNT_WIDTH  total drops, saturating.
- busy_o  out  1  holdoff counter nonzero.

## Operation
- Acceptance: source s is accepted when req_valid_i[s], running_i and src_enable_i[s] are all high. On acceptance, trig/metadata are captured into pending[s] and pend[s] is set on the next edge.
- Drop: an accepted request into a source whose pend[s] is set and is not being granted on the same edge is dropped. The held request is kept. drop_o[s] is set, and drop_cnt_o increments by the number of sources dropping that cycle, saturating at all-ones.
- Requests while !running_i or with the source disabled are ignored and are not counted as drops.
- !running_i clears all pend bits every cycle. Deasserting src_enable_i[s] clears pend[s] on the next edge.
- Grant eligibility: slot_ce_i high, running_i high, hold_cnt == 0, and at least one pend bit set.
- Winner: the first set pend bit searching upward mod 4 from rr_ptr.
- On grant:
  - the output registers load the winner's data, and src_o loads the winner's index;
  - valid_o is high for the following cycle only;
  - pend[winner] is cleared, unless a new accepted request for that source arrives on the same edge, in which case it reloads (no drop);
  - rr_ptr is set to winner+1 mod 4;
  - hold_cnt is loaded with holdoff_i.
- Holdoff: on each slot_ce_i with hold_cnt nonzero and no grant, hold_cnt decrements. holdoff_i = 0 permits grants on consecutive slots. holdoff_i changes take effect at the next load.
- clear_i zeroes drop_o and drop_cnt_o on the next edge. A drop on the same edge as clear_i wins: the flag is set and the count is 1.
- Reset values:
  - pend, rr_ptr, hold_cnt, valid_o, trig_o, metadata_o, src_o, drop_o, drop_cnt_o, busy_o are all 0.
  - Reset mid-operation discards pending requests without counting drops.

## Timing
- Request to pend visible: 1 cycle.
- Earliest grant: the first slot_ce_i at least one cycle after acceptance. A request arriving on the slot cycle itself is not eligible for that slot.
- Grant: slot_ce_i at cycle N produces valid_o/trig_o/metadata_o/src_o at N+1. Data outputs hold until the next grant.
- busy_o is registered and equals (hold_cnt != 0).
- Minimum grant spacing is holdoff_i+1 slots.

## Structure
- Package pueo_trig_pkg holds:
  - constants NTURF_SRC = 4, SRC_SOFT = 0, SRC_PPS = 1, SRC_EXT = 2, SRC_RSV = 3;
  - typedef struct turf_trig_req_t {logic [11:0] trig; logic [7:0] metadata;}.
- Sub-module rr_pick4: a combinational round-robin picker taking pend[3:0] and ptr[1:0], returning any and idx[1:0]. It is reused by other arbiters.

## Test plan
- Single request: soft request (trig 0x123, meta 0x5A), holdoff 0 → valid_o one cycle after the next slot with src_o = 0, trig_o = 0x123, metadata_o = 0x5A; no drops.
- Round robin: all four sources request simultaneously, holdoff 0 → grants on four consecutive slots in order 0,1,2,3. Then re-requesting 1 and 3 grants 1 first, since rr_ptr is 0 after granting 3.
- Holdoff: holdoff 2 with two pending sources → the second grant arrives exactly 3 slots after the first, and busy_o is high in between.
- Drop and clear:
  - pps requests twice before a slot → drop_o = 0b0010, drop_cnt_o = 1, and the first request's data is granted.
  - clear_i → both zero.
  - drop_cnt_o saturates at 0xFFFF after 65540 forced drops.
- Run/enable gating:
  - running_i low with requests → no valid_o and no drops.
  - Disabling ext while it is pending → pend cleared and no grant.
  - Reset asserted mid-holdoff → all outputs are 0 the next cycle.
